// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line levels.
// Used by both the transmit serializer and the future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: start bit, LSB-first data, optional parity, stop bit(s).
// Define UART_TX_PARITY_EN to add the parity bit and the i_parity_odd port.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_tick,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
`ifdef UART_TX_PARITY_EN
    input  logic                 i_parity_odd,
`endif
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    tx_state_e            state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    assign bit_end = i_tick && (tick_cnt == TICK_LAST);

    // bit_cnt counts data bits in DATA and stop bits in STOP; o_tx is always the
    // value of the bit currently on the line, loaded one bit ahead at each bit end.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= TX_IDLE;
            o_tx       <= UART_IDLE_LEVEL;
            o_ready    <= 1'b1;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            shift_reg  <= '0;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            if (state != TX_IDLE && i_tick) begin
                tick_cnt <= bit_end ? '0 : tick_cnt + TICK_W'(1);
            end

            case (state)
                TX_IDLE: begin
                    if (i_valid && o_ready) begin
                        shift_reg  <= i_data;
                        tick_cnt   <= '0;
                        bit_cnt    <= '0;
                        o_tx       <= UART_START_LEVEL;
                        o_ready    <= 1'b0;
                        o_busy     <= 1'b1;
                        state      <= TX_START;
`ifdef UART_TX_PARITY_EN
                        // Same byte that lands in shift_reg, so equal to parity of the latched data.
                        parity_bit <= (^i_data) ^ i_parity_odd;
`endif
                    end
                end

                TX_START: begin
                    if (bit_end) begin
                        o_tx  <= shift_reg[0];
                        state <= TX_DATA;
                    end
                end

                TX_DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            o_tx    <= parity_bit;
                            state   <= TX_PARITY;
`else
                            o_tx    <= UART_IDLE_LEVEL;
                            state   <= TX_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            o_tx    <= shift_reg[1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    if (bit_end) begin
                        o_tx  <= UART_IDLE_LEVEL;
                        state <= TX_STOP;
                    end
                end
`endif

                TX_STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= TX_IDLE;
                            o_done  <= 1'b1;
                            o_ready <= 1'b1;
                            o_busy  <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end

                default: begin
                    state   <= TX_IDLE;
                    o_tx    <= UART_IDLE_LEVEL;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer against a frame-level bit-list model.
// Exercises the parity path when compiled with UART_TX_PARITY_EN.
module tb_uart_tx_serializer;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       valid, valid2;
    logic [7:0] data_in, data2;
    logic       parity_odd;
    logic       ready, tx, busy, done;
    logic       ready2, tx2, busy2, done2;

    int vectors     = 0;
    int miscompares = 0;
    int tick_period = 4;
    int phase       = 0;
    bit tick_en     = 1'b1;
    bit last_tick   = 1'b0;
    int done_count  = 0;
    bit exp_bits[$];

    always #5 clk = ~clk;

    uart_tx_serializer #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(1)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_tick       (tick),
        .i_valid      (valid),
        .i_data       (data_in),
`ifdef UART_TX_PARITY_EN
        .i_parity_odd (parity_odd),
`endif
        .o_ready      (ready),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_done       (done)
    );

    uart_tx_serializer #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(2)) dut2 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_tick       (tick),
        .i_valid      (valid2),
        .i_data       (data2),
`ifdef UART_TX_PARITY_EN
        .i_parity_odd (parity_odd),
`endif
        .o_ready      (ready2),
        .o_tx         (tx2),
        .o_busy       (busy2),
        .o_done       (done2)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive the oversample strobe for this cycle, sample 1 time unit after the edge.
    task automatic cycle();
        last_tick = tick_en && (phase == tick_period - 1);
        tick      = last_tick;
        phase     = (phase + 1) % tick_period;
        @(posedge clk);
        #1;
    endtask

    // Reference frame: start, LSB-first data, optional parity, stop bits.
    function automatic void build_frame(input logic [7:0] data, input bit odd, input int stops);
        int ones = 0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_bits.push_back(data[i]);
            ones += int'(data[i]);
        end
`ifdef UART_TX_PARITY_EN
        exp_bits.push_back(bit'((ones % 2) ^ int'(odd)));
`endif
        for (int i = 0; i < stops; i++) exp_bits.push_back(1'b1);
    endfunction

    task automatic sample(input int which, input int ticks, input int total);
        logic etx;
        etx = (ticks < total) ? exp_bits[ticks / OS] : 1'b1;
        check($sformatf("tx%0d@tick%0d", which, ticks), (which == 1) ? tx2 : tx, etx);
        check($sformatf("busy%0d@tick%0d", which, ticks), (which == 1) ? busy2 : busy, ticks < total);
        check($sformatf("ready%0d@tick%0d", which, ticks), (which == 1) ? ready2 : ready, ticks >= total);
        check($sformatf("done%0d@tick%0d", which, ticks), (which == 1) ? done2 : done, ticks == total);
        if (((which == 1) ? done2 : done) === 1'b1) done_count++;
    endtask

    task automatic check_idle(input int which, input string tag);
        cycle();
        check({tag, "_tx"},    (which == 1) ? tx2 : tx, 1'b1);
        check({tag, "_busy"},  (which == 1) ? busy2 : busy, 1'b0);
        check({tag, "_ready"}, (which == 1) ? ready2 : ready, 1'b1);
        check({tag, "_done"},  (which == 1) ? done2 : done, 1'b0);
    endtask

    // Sends one byte and checks every cycle until the final stop tick; leaves the bench in the o_done cycle.
    task automatic run_frame(input int which, input logic [7:0] data, input bit odd,
                             input bit keep_valid, input int gate_at);
        int ticks = 0;
        int total;
        bit gated = 1'b0;
        build_frame(data, odd, (which == 1) ? 2 : 1);
        total = exp_bits.size() * OS;
        $display("[TB] frame dut%0d data=%h odd=%0d period=%0d", which, data, odd, tick_period);
        if (which == 1) begin
            valid2 = 1'b1;
            data2  = data;
        end else begin
            valid   = 1'b1;
            data_in = data;
        end
        parity_odd = odd;
        cycle();
        if (!keep_valid) begin
            valid  = 1'b0;
            valid2 = 1'b0;
        end
        data_in    = 8'($urandom);
        data2      = 8'($urandom);
        parity_odd = 1'($urandom);
        sample(which, ticks, total);
        while (ticks < total) begin
            if (gate_at > 0 && ticks == gate_at && !gated) begin
                gated   = 1'b1;
                tick_en = 1'b0;
                repeat (1000) begin
                    cycle();
                    sample(which, ticks, total);
                end
                tick_en = 1'b1;
            end
            cycle();
            if (last_tick) ticks++;
            sample(which, ticks, total);
        end
    endtask

    initial begin
        int ticks;
        rst_n = 1'b0; tick = 1'b0; valid = 1'b0; valid2 = 1'b0;
        data_in = '0; data2 = '0; parity_odd = 1'b0;
        repeat (3) cycle();
        check("rst_tx", tx, 1'b1);
        check("rst_ready", ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tx2", tx2, 1'b1);
        check("rst_done2", done2, 1'b0);
        rst_n = 1'b1;

        // Ticks while idle must not move the line
        repeat (20) check_idle(0, "idle");

        tick_period = 4; phase = 0;
        run_frame(0, 8'hA5, 1'b0, 1'b0, 0);
        check_idle(0, "after_a5");

        // Back-to-back with i_valid held high
        done_count = 0;
        run_frame(0, 8'h00, 1'b0, 1'b1, 0);
        run_frame(0, 8'hFF, 1'b0, 1'b0, 0);
        check("b2b_done_count", 16'(done_count), 16'd2);
        check_idle(0, "after_b2b");

        // Ticks stalled for 1000 clocks in the middle of data bit 2
        run_frame(0, 8'h6B, 1'b0, 1'b0, 3 * OS + 5);
        check_idle(0, "after_gate");

        // Reset during data bit 3 of 0x3C
        build_frame(8'h3C, 1'b0, 1);
        valid = 1'b1; data_in = 8'h3C;
        cycle();
        valid = 1'b0;
        ticks = 0;
        done_count = 0;
        while (ticks < 4 * OS + 8) begin
            cycle();
            if (last_tick) ticks++;
            sample(0, ticks, exp_bits.size() * OS);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_ready", ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (40) check_idle(0, "post_rst");
        check("midrst_no_done", 16'(done_count), 16'd0);
        run_frame(0, 8'h55, 1'b0, 1'b0, 0);
        check_idle(0, "after_55");

`ifdef UART_TX_PARITY_EN
        run_frame(0, 8'h07, 1'b0, 1'b0, 0);
        check_idle(0, "par_even");
        run_frame(0, 8'h07, 1'b1, 1'b0, 0);
        check_idle(0, "par_odd");
`endif

        // Two stop bits
        run_frame(1, 8'h81, 1'b0, 1'b0, 0);
        check_idle(1, "stop2");

        // Random bytes at random tick spacing
        for (int r = 0; r < 6; r++) begin
            tick_period = int'($urandom_range(4, 1));
            phase = 0;
            run_frame(r % 3 == 2 ? 1 : 0, 8'($urandom), 1'($urandom), 1'b0, 0);
            check_idle(r % 3 == 2 ? 1 : 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit engine; consumes the oversampling tick from the baud generator and serializes one byte per frame onto the TX line.
- Frame format: start bit, DATA_BITS data bits (LSB first), optional parity, STOP_BITS stop bits.
- Sits between the TX FIFO/register interface (valid/ready) and the pad.

Parameters:
- DATA_BITS, 8, data bits per frame; legal values 5..9.
- OVERSAMPLE, 16, i_tick pulses per bit period; must be ≥2.
- STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_tick  in  1  one-cycle oversample strobe from the baud generator.
- i_valid  in  1  byte available on i_data.
- i_data  in  DATA_BITS  byte to send; sampled only on handshake.
- o_ready  out  1  engine can accept a byte.
- o_tx  out  1  serial line, idle high, registered.
- o_busy  out  1  frame in progress (state != IDLE).
- o_done  out  1  one-cycle pulse when the final stop bit completes.
- i_parity_odd  in  1  (UART_TX_PARITY_EN only) 1 = odd parity, 0 = even parity.

Behaviour:
- Reset (async assert, sync release) forces these values:
  - state IDLE, o_tx=1, o_ready=1, o_busy=0, o_done=0.
  - shift register, tick counter and bit counter = 0.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Handshake: transfer occurs on a rising edge where i_valid & o_ready.
  - On that edge: latch i_data, clear tick_cnt, enter START.
  - o_tx goes low on the same edge (visible the next cycle).
  - o_ready deasserts the cycle after the handshake.
- tick_cnt width is $clog2(OVERSAMPLE).
  - Increments only on cycles with i_tick=1.
  - A bit ends on the i_tick cycle where tick_cnt==OVERSAMPLE-1; tick_cnt then wraps to 0.
- i_tick is ignored in IDLE.
- Bit length is exactly OVERSAMPLE ticks, measured from the first tick after the handshake. The start bit may therefore be stretched by up to one tick interval; this is accepted.
- START: o_tx=0. At bit end, o_tx = shift[0] and state = DATA.
- DATA:
  - At each bit end, shift right and increment bit_cnt.
  - After bit DATA_BITS-1, go to PARITY (feature on) or STOP (feature off), with o_tx = parity or 1 respectively.
- STOP:
  - o_tx=1 for STOP_BITS*OVERSAMPLE ticks.
  - On the final tick: state = IDLE, o_done=1 for one cycle, o_ready=1.
- Back-to-back: a new handshake is allowed in the first IDLE cycle, i.e. the cycle in which o_done is high. No idle bit time is inserted.
- i_data changes after the handshake have no effect on the frame in flight.
- i_valid deasserted mid-frame has no effect.
- i_valid held high in IDLE starts a new frame immediately.
- Reset mid-frame: o_tx returns to 1 asynchronously and the frame is abandoned. o_done does not pulse.
- o_tx is glitch-free: driven only from a flop.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds port i_parity_odd and state PARITY (one bit period).
  - Parity bit = ^data XOR i_parity_odd, computed from the latched byte. i_parity_odd is sampled at handshake.
- Undefined:
  - No parity port and no PARITY state.
  - DATA transitions straight to STOP.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] tx_state_e {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP}.
  - Constants UART_IDLE_LEVEL=1'b1, UART_START_LEVEL=1'b0.
  - Shared with the future receiver.
- No sub-module. The tick counter is inline; the baud generator is instantiated at the top level, not inside this block.

Test Plan:
- Frame check. Setup: OVERSAMPLE=16, i_tick every 4 clocks. Send 0xA5 (parity off). Required:
  - o_tx sequence 0,1,0,1,0,0,1,0,1,1.
  - Each bit 64 clocks (±4 on the start bit).
  - o_done is a single-cycle pulse after the stop bit.
- Back-to-back: hold i_valid=1 with 0x00 then 0xFF. Required:
  - The second start bit immediately follows the first stop bit, with no extra idle.
  - Exactly two o_done pulses.
- Tick gating:
  - Hold i_tick=0 for 1000 clocks mid-DATA: o_tx is frozen and state is unchanged.
  - Then resume ticks: the frame completes correctly.
- Reset mid-frame: assert i_rst_n=0 during bit 3 of 0x3C. Required:
  - o_tx=1, o_ready=1, o_busy=0 immediately.
  - No o_done pulse.
  - The next byte 0x55 is sent cleanly.
- Parity (UART_TX_PARITY_EN):
  - 0x07 with odd=0 gives parity bit 1.
  - 0x07 with odd=1 gives parity bit 0.
  - Total frame length is 11 bits.
- STOP_BITS=2: send 0x81. Required: the stop high lasts 2*OVERSAMPLE ticks before o_done.
